// File: rtl/bcd_conv_arbiter.sv
// Shared multi-cycle binary-to-BCD converter (serial double dabble) with a
// two-requester round-robin arbiter and req/done handshake per requester.
module bcd_conv_arbiter #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_i,
    input  logic [BIN_W-1:0]      bin0_i,
    input  logic                  req1_i,
    input  logic [BIN_W-1:0]      bin1_i,
    output logic                  busy_o,
    output logic                  gnt_id_o,
    output logic                  done0_o,
    output logic                  done1_o,
    output logic [4*DIGITS-1:0]   bcd_out_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BIN_W + BCD_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SR_W-1:0]  sr_q,    sr_d;
    logic             last_q,  last_d;
    logic             gnt_q,   gnt_d;
    logic             busy_q,  busy_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [BCD_W-1:0] bcd_q,   bcd_d;

    logic [SR_W-1:0]  adj_c;
    logic             pick_c;

    // Add-3 correction: every digit judged on its pre-add value.
    always_comb begin
        adj_c = sr_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                adj_c[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // On a tie the requester not served last wins.
    always_comb begin
        pick_c = (req0_i && req1_i) ? ~last_q : req1_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        bcd_d   = bcd_q;

        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    sr_d    = pick_c ? SR_W'(bin1_i) : SR_W'(bin0_i);
                    cnt_d   = '0;
                    gnt_d   = pick_c;
                    last_d  = pick_c;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = SR_W'({adj_c, 1'b0});
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bcd_d   = sr_d[SR_W-1 -: BCD_W];
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy_o    = busy_q;
    assign gnt_id_o  = gnt_q;
    assign done0_o   = done0_q;
    assign done1_o   = done1_q;
    assign bcd_out_o = bcd_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_bcd_conv_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [11:0] bin0, bin1;
    logic        busy, gnt_id, done0, done1;
    logic [15:0] bcd_out;

    typedef struct {
        bit          id;
        logic [15:0] bcd;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ndone  = 0;

    bcd_conv_arbiter #(.BIN_W(12), .DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_i    (req0),
        .bin0_i    (bin0),
        .req1_i    (req1),
        .bin1_i    (bin1),
        .busy_o    (busy),
        .gnt_id_o  (gnt_id),
        .done0_o   (done0),
        .done1_o   (done1),
        .bcd_out_o (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done0 || done1) begin
                ndone++;
                checks++;
                if (done0 && done1) begin
                    errors++;
                    $display("FAIL both_done: done0 and done1 high together at cycle %0d", cyc);
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done0=%0b done1=%0b bcd=%h cycle %0d",
                             done0, done1, bcd_out, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (done1 !== e.id || gnt_id !== e.id || bcd_out !== e.bcd || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result: got id=%0b gnt=%0b bcd=%h cyc=%0d expected id=%0b bcd=%h cyc=%0d",
                                 done1, gnt_id, bcd_out, cyc, e.id, e.bcd, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit id, input logic [15:0] bcd, input int at);
        exp_t e;
        e.id  = id;
        e.bcd = bcd;
        e.cyc = at;
        sb_q.push_back(e);
    endtask

    // Waits (bounded) at negedges until the requester's done is seen.
    task automatic wait_done(input bit id, input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if ((id ? done1 : done0) === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: done%0d never seen", name, id);
        end
    endtask

    task automatic single(input bit id, input logic [11:0] b, input logic [15:0] exp, input string name);
        @(negedge clk);
        if (id) begin req1 = 1'b1; bin1 = b; end
        else    begin req0 = 1'b1; bin0 = b; end
        push_exp(id, exp, cyc + 13);
        wait_done(id, name);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        req0  = 1'($urandom);
        req1  = 1'($urandom);
        bin0  = 12'($urandom);
        bin1  = 12'($urandom);

        // Reset with random inputs
        repeat (3) @(negedge clk);
        check_eq("rst_busy",   32'(busy),    32'd0);
        check_eq("rst_gnt",    32'(gnt_id),  32'd0);
        check_eq("rst_done0",  32'(done0),   32'd0);
        check_eq("rst_done1",  32'(done1),   32'd0);
        check_eq("rst_bcd",    32'(bcd_out), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("idle_busy",  32'(busy),    32'd0);

        // Single conversions
        single(1'b0, 12'd4095, 16'h4095, "max");
        @(negedge clk);
        check_eq("after_done_busy", 32'(busy), 32'd0);
        single(1'b0, 12'd0,    16'h0000, "zero");
        single(1'b0, 12'd9,    16'h0009, "nine");
        single(1'b1, 12'd999,  16'h0999, "r1_999");
        check_eq("hold_bcd", 32'(bcd_out), 32'h0999);

        // Simultaneous requests straight after reset
        do_reset();
        @(negedge clk);
        req0 = 1'b1; bin0 = 12'd1234;
        req1 = 1'b1; bin1 = 12'd987;
        push_exp(1'b0, 16'h1234, cyc + 13);
        push_exp(1'b1, 16'h0987, cyc + 27);
        wait_done(1'b0, "sim0");
        req0 = 1'b0;
        wait_done(1'b1, "sim1");
        req1 = 1'b0;

        // Round robin with both requests held for 8 conversions
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b1; bin0 = 12'd500;
        req1 = 1'b1; bin1 = 12'd2048;
        n0 = ndone;
        for (int k = 0; k < 8; k++)
            push_exp(1'(k % 2), (k % 2) ? 16'h2048 : 16'h0500, cyc + 13 + 14 * k);
        for (int k = 0; k < 200 && (ndone - n0) < 8; k++) @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        check_eq("rr_count", 32'(ndone - n0), 32'd8);

        // Operand capture and dropped request
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b1; bin0 = 12'd9;
        push_exp(1'b0, 16'h0009, cyc + 13);
        repeat (5) @(negedge clk);
        bin0 = 12'd100;
        @(negedge clk);
        req0 = 1'b0;
        wait_done(1'b0, "capture");

        // Reset in the middle of a requester-1 conversion
        @(negedge clk);
        @(negedge clk);
        req1 = 1'b1; bin1 = 12'd321;
        repeat (6) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_eq("mid_gnt",  32'(gnt_id), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy",  32'(busy),    32'd0);
        check_eq("abort_gnt",   32'(gnt_id),  32'd0);
        check_eq("abort_done1", 32'(done1),   32'd0);
        check_eq("abort_bcd",   32'(bcd_out), 32'd0);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("abort_idle", 32'(busy), 32'd0);

        // Tie after reset goes to requester 0
        req0 = 1'b1; bin0 = 12'd42;
        req1 = 1'b1; bin1 = 12'd7;
        push_exp(1'b0, 16'h0042, cyc + 13);
        push_exp(1'b1, 16'h0007, cyc + 27);
        wait_done(1'b0, "tie0");
        req0 = 1'b0;
        wait_done(1'b1, "tie1");
        req1 = 1'b0;

        repeat (20) @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
